// File: rtl/x_ramb_tdp_asym.sv
// x_ramb_tdp_asym: single-clock true-dual-port RAM whose two ports see one
// shared bit array at independent power-of-two widths.
//
// Ports
//   CLK            rising-edge clock for both ports
//   RST_N          asynchronous active-low reset of the output/collision regs
//   ENA/ENB        port enable
//   WEA/WEB        write enable (qualified by the port enable)
//   RSTA/RSTB      synchronous output reset to SRVAL_A/SRVAL_B, active high
//   ADDRA/ADDRB    word address at the port's own width
//   DIA/DIB        write data
//   DOA/DOB        read data (latency 1, or 2 with DO_REG=1)
//   COLL           one-cycle pulse in the cycle after an A/B collision
//
// Word a of a port of width W occupies array bits [a*W +: W]. On a
// write/write overlap port A wins the shared bits. A port that reads a word
// being written by the other port sees the pre-edge array contents.
// The array has no reset and no file preload; INIT_FILE must be "NONE".
module x_ramb_tdp_asym #(
  parameter int                 MEM_BITS     = 4096,
  parameter int                 WIDTH_A      = 1,
  parameter int                 WIDTH_B      = 2,
  parameter string              WRITE_MODE_A = "WRITE_FIRST",
  parameter string              WRITE_MODE_B = "WRITE_FIRST",
  parameter int                 DO_REG       = 0,
  parameter logic [WIDTH_A-1:0] SRVAL_A      = '0,
  parameter logic [WIDTH_B-1:0] SRVAL_B      = '0,
  parameter string              INIT_FILE    = "NONE",
  localparam int                ADDR_A_W     = $clog2(MEM_BITS / WIDTH_A),
  localparam int                ADDR_B_W     = $clog2(MEM_BITS / WIDTH_B)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                ENA,
  input  logic                WEA,
  input  logic                RSTA,
  input  logic [ADDR_A_W-1:0] ADDRA,
  input  logic [WIDTH_A-1:0]  DIA,
  output logic [WIDTH_A-1:0]  DOA,
  input  logic                ENB,
  input  logic                WEB,
  input  logic                RSTB,
  input  logic [ADDR_B_W-1:0] ADDRB,
  input  logic [WIDTH_B-1:0]  DIB,
  output logic [WIDTH_B-1:0]  DOB,
  output logic                COLL
);

  localparam int IDX_W    = $clog2(MEM_BITS);
  localparam int LOG_WA   = $clog2(WIDTH_A);
  localparam int LOG_WB   = $clog2(WIDTH_B);
  localparam int LOG_WMAX = (LOG_WA > LOG_WB) ? LOG_WA : LOG_WB;

  typedef enum logic [1:0] {WM_WRITE_FIRST, WM_READ_FIRST, WM_NO_CHANGE} wmode_e;

  localparam wmode_e MODE_A = (WRITE_MODE_A == "READ_FIRST") ? WM_READ_FIRST :
                              (WRITE_MODE_A == "NO_CHANGE")  ? WM_NO_CHANGE  : WM_WRITE_FIRST;
  localparam wmode_e MODE_B = (WRITE_MODE_B == "READ_FIRST") ? WM_READ_FIRST :
                              (WRITE_MODE_B == "NO_CHANGE")  ? WM_NO_CHANGE  : WM_WRITE_FIRST;

  localparam bit MODE_A_OK = (WRITE_MODE_A == "WRITE_FIRST") || (WRITE_MODE_A == "READ_FIRST") ||
                             (WRITE_MODE_A == "NO_CHANGE");
  localparam bit MODE_B_OK = (WRITE_MODE_B == "WRITE_FIRST") || (WRITE_MODE_B == "READ_FIRST") ||
                             (WRITE_MODE_B == "NO_CHANGE");

  // Geometry and mode legality is settled at elaboration.
  if ((MEM_BITS < 2) || ((MEM_BITS & (MEM_BITS - 1)) != 0)) begin : g_bad_mem_bits
    $error("x_ramb_tdp_asym: MEM_BITS must be a power of two");
  end
  if ((WIDTH_A < 1) || ((WIDTH_A & (WIDTH_A - 1)) != 0) || (WIDTH_A >= MEM_BITS)) begin : g_bad_width_a
    $error("x_ramb_tdp_asym: WIDTH_A must be a power of two narrower than the array");
  end
  if ((WIDTH_B < 1) || ((WIDTH_B & (WIDTH_B - 1)) != 0) || (WIDTH_B >= MEM_BITS)) begin : g_bad_width_b
    $error("x_ramb_tdp_asym: WIDTH_B must be a power of two narrower than the array");
  end
  if (!MODE_A_OK || !MODE_B_OK) begin : g_bad_mode
    $error("x_ramb_tdp_asym: WRITE_MODE must be WRITE_FIRST, READ_FIRST or NO_CHANGE");
  end
  if ((DO_REG != 0) && (DO_REG != 1)) begin : g_bad_do_reg
    $error("x_ramb_tdp_asym: DO_REG must be 0 or 1");
  end
  if (INIT_FILE != "NONE") begin : g_bad_init
    $error("x_ramb_tdp_asym: file preload is not available, INIT_FILE must be NONE");
  end

  logic [MEM_BITS-1:0] mem_q, mem_d;
  logic [IDX_W-1:0]    base_a, base_b;
  logic                wr_a, wr_b, overlap;
  logic [WIDTH_A-1:0]  old_a, rd_a_q, rd_a_d, do_a_q, do_a_d;
  logic [WIDTH_B-1:0]  old_b, rd_b_q, rd_b_d, do_b_q, do_b_d;
  logic                coll_q, coll_d;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first so no latch is inferred; clocked blocks use only '<='.
  always_comb begin
    base_a  = IDX_W'(ADDRA) << LOG_WA;
    base_b  = IDX_W'(ADDRB) << LOG_WB;
    old_a   = mem_q[base_a +: WIDTH_A];
    old_b   = mem_q[base_b +: WIDTH_B];
    // Both words are aligned to their own width, so they overlap exactly
    // when they sit in the same aligned block of the wider port.
    overlap = (base_a >> LOG_WMAX) == (base_b >> LOG_WMAX);
    wr_a    = RST_N && ENA && WEA;
    wr_b    = RST_N && ENB && WEB;
    coll_d  = RST_N && ENA && ENB && (WEA || WEB) && overlap;

    // B is applied first so A's data wins the shared bits of a double write.
    mem_d = mem_q;
    if (wr_b) mem_d[base_b +: WIDTH_B] = DIB;
    if (wr_a) mem_d[base_a +: WIDTH_A] = DIA;
  end

  // Reads take old_x from the pre-edge array, which gives a reading port
  // the old data on bits the other port is writing this edge.
  always_comb begin
    rd_a_d = rd_a_q;
    if (ENA) begin
      if (WEA) begin
        case (MODE_A)
          WM_READ_FIRST: rd_a_d = old_a;
          WM_NO_CHANGE:  rd_a_d = rd_a_q;
          default:       rd_a_d = DIA;
        endcase
      end else begin
        rd_a_d = old_a;
      end
      if (RSTA && (DO_REG == 0)) rd_a_d = SRVAL_A;
    end
    do_a_d = RSTA ? SRVAL_A : rd_a_q;
  end

  always_comb begin
    rd_b_d = rd_b_q;
    if (ENB) begin
      if (WEB) begin
        case (MODE_B)
          WM_READ_FIRST: rd_b_d = old_b;
          WM_NO_CHANGE:  rd_b_d = rd_b_q;
          default:       rd_b_d = DIB;
        endcase
      end else begin
        rd_b_d = old_b;
      end
      if (RSTB && (DO_REG == 0)) rd_b_d = SRVAL_B;
    end
    do_b_d = RSTB ? SRVAL_B : rd_b_q;
  end

  // NOTE: the array is deliberately left out of reset so it maps onto block
  // RAM and keeps its contents across RST_N; writes are gated by RST_N above.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_a_q <= SRVAL_A;
      rd_b_q <= SRVAL_B;
      do_a_q <= SRVAL_A;
      do_b_q <= SRVAL_B;
      coll_q <= 1'b0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
      do_a_q <= do_a_d;
      do_b_q <= do_b_d;
      coll_q <= coll_d;
    end
  end

  assign DOA  = (DO_REG != 0) ? do_a_q : rd_a_q;
  assign DOB  = (DO_REG != 0) ? do_b_q : rd_b_q;
  assign COLL = coll_q;

endmodule

// File: tb/tb_x_ramb_tdp_asym.sv
// Self-checking bench for x_ramb_tdp_asym. Four instances share one stimulus
// stream: default modes, READ_FIRST on both ports, NO_CHANGE on port B, and
// a DO_REG=1 variant with SRVAL_B=2'b11. Expected values are queued as the
// stimulus is driven and popped after the edge (or reset) that produces them.
module tb_x_ramb_tdp_asym;

  logic        clk = 1'b0;
  logic        rst_n, ena, wea, rsta, enb, web, rstb, dia;
  logic [11:0] addra;
  logic [10:0] addrb;
  logic [1:0]  dib;

  logic       wf_doa, rf_doa, nc_doa, rg_doa;
  logic [1:0] wf_dob, rf_dob, nc_dob, rg_dob;
  logic       wf_coll, rf_coll, nc_coll, rg_coll;

  int n_assert = 0;
  int n_fail   = 0;

  typedef enum int {
    WF_DOA, WF_DOB, WF_COLL, RF_DOA, RF_DOB, RF_COLL, NC_DOB, RG_DOA, RG_DOB, RG_COLL
  } obs_e;

  typedef struct {
    string      tag;
    obs_e       sel;
    logic [1:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  x_ramb_tdp_asym u_wf (
    .CLK(clk), .RST_N(rst_n),
    .ENA(ena), .WEA(wea), .RSTA(rsta), .ADDRA(addra), .DIA(dia), .DOA(wf_doa),
    .ENB(enb), .WEB(web), .RSTB(rstb), .ADDRB(addrb), .DIB(dib), .DOB(wf_dob),
    .COLL(wf_coll)
  );

  x_ramb_tdp_asym #(.WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("READ_FIRST")) u_rf (
    .CLK(clk), .RST_N(rst_n),
    .ENA(ena), .WEA(wea), .RSTA(rsta), .ADDRA(addra), .DIA(dia), .DOA(rf_doa),
    .ENB(enb), .WEB(web), .RSTB(rstb), .ADDRB(addrb), .DIB(dib), .DOB(rf_dob),
    .COLL(rf_coll)
  );

  x_ramb_tdp_asym #(.WRITE_MODE_B("NO_CHANGE")) u_nc (
    .CLK(clk), .RST_N(rst_n),
    .ENA(ena), .WEA(wea), .RSTA(rsta), .ADDRA(addra), .DIA(dia), .DOA(nc_doa),
    .ENB(enb), .WEB(web), .RSTB(rstb), .ADDRB(addrb), .DIB(dib), .DOB(nc_dob),
    .COLL(nc_coll)
  );

  x_ramb_tdp_asym #(.DO_REG(1), .SRVAL_B(2'b11)) u_rg (
    .CLK(clk), .RST_N(rst_n),
    .ENA(ena), .WEA(wea), .RSTA(rsta), .ADDRA(addra), .DIA(dia), .DOA(rg_doa),
    .ENB(enb), .WEB(web), .RSTB(rstb), .ADDRB(addrb), .DIB(dib), .DOB(rg_dob),
    .COLL(rg_coll)
  );

  function automatic logic [1:0] observe(obs_e sel);
    case (sel)
      WF_DOA:  return {1'b0, wf_doa};
      WF_DOB:  return wf_dob;
      WF_COLL: return {1'b0, wf_coll};
      RF_DOA:  return {1'b0, rf_doa};
      RF_DOB:  return rf_dob;
      RF_COLL: return {1'b0, rf_coll};
      NC_DOB:  return nc_dob;
      RG_DOA:  return {1'b0, rg_doa};
      RG_DOB:  return rg_dob;
      default: return {1'b0, rg_coll};
    endcase
  endfunction

  task automatic push_exp(input string tag, input obs_e sel, input logic [1:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t       e;
    logic [1:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_assert++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; wea = 1'b0; rsta = 1'b0;
    enb = 1'b0; web = 1'b0; rstb = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; idle();
    addra = '0; dia = 1'b0; addrb = '0; dib = '0;
    tick();

    // Asynchronous reset mid-cycle.
    #3 rst_n = 1'b0;
    push_exp("rst_doa",     WF_DOA,  2'b00);
    push_exp("rst_dob",     WF_DOB,  2'b00);
    push_exp("rst_coll",    WF_COLL, 2'b00);
    push_exp("rst_srval_b", RG_DOB,  2'b11);
    #1 check_sb();
    tick();
    tick();
    rst_n = 1'b1;

    // Clear the low 32 array bits through port B.
    for (int i = 0; i < 16; i++) begin
      enb = 1'b1; web = 1'b1; addrb = 11'(i); dib = 2'b00;
      tick();
    end
    idle();

    // Cross-width mapping: A bits 6,7 form B word 3.
    ena = 1'b1; wea = 1'b1; addra = 12'd6; dia = 1'b1;
    tick();
    addra = 12'd7;
    tick();
    wea = 1'b0; addra = 12'd7; enb = 1'b1; web = 1'b0; addrb = 11'd3;
    push_exp("map_dob",      WF_DOB,  2'b11);
    push_exp("map_doa",      WF_DOA,  2'b01);
    push_exp("rdrd_no_coll", WF_COLL, 2'b00);
    push_exp("doreg_lat1",   RG_DOB,  2'b00);
    tick();
    check_sb();
    idle();
    push_exp("doreg_lat2", RG_DOB, 2'b11);
    tick();
    check_sb();

    // Port B write modes at address 5.
    enb = 1'b1; web = 1'b1; addrb = 11'd5; dib = 2'b01;
    tick();
    dib = 2'b10;
    push_exp("wm_write_first", WF_DOB, 2'b10);
    push_exp("wm_read_first",  RF_DOB, 2'b01);
    push_exp("wm_no_change",   NC_DOB, 2'b11);
    tick();
    check_sb();
    web = 1'b0;
    push_exp("wm_rd_wf", WF_DOB, 2'b10);
    push_exp("wm_rd_rf", RF_DOB, 2'b10);
    push_exp("wm_rd_nc", NC_DOB, 2'b10);
    tick();
    check_sb();

    // Write/write collision: A bit 10 against B word 5.
    web = 1'b1; dib = 2'b00;
    tick();
    ena = 1'b1; wea = 1'b1; addra = 12'd10; dia = 1'b1;
    enb = 1'b1; web = 1'b1; addrb = 11'd5;  dib = 2'b00;
    push_exp("ww_coll",     WF_COLL, 2'b01);
    push_exp("ww_coll_reg", RG_COLL, 2'b01);
    push_exp("ww_doa_wf",   WF_DOA,  2'b01);
    push_exp("ww_doa_rf",   RF_DOA,  2'b00);
    push_exp("ww_dob_wf",   WF_DOB,  2'b00);
    push_exp("ww_dob_rf",   RF_DOB,  2'b00);
    tick();
    check_sb();
    idle(); enb = 1'b1; addrb = 11'd5;
    push_exp("ww_a_wins_wf", WF_DOB,  2'b01);
    push_exp("ww_a_wins_rf", RF_DOB,  2'b01);
    push_exp("ww_a_wins_nc", NC_DOB,  2'b01);
    push_exp("ww_coll_drop", WF_COLL, 2'b00);
    tick();
    check_sb();

    // Read/write collision: A writes bit 11 while B reads word 5.
    idle(); ena = 1'b1; wea = 1'b1; addra = 12'd10; dia = 1'b0;
    tick();
    ena = 1'b1; wea = 1'b1; addra = 12'd11; dia = 1'b1;
    enb = 1'b1; web = 1'b0; addrb = 11'd5;
    push_exp("rw_old_wf", WF_DOB,  2'b00);
    push_exp("rw_old_rf", RF_DOB,  2'b00);
    push_exp("rw_coll",   RF_COLL, 2'b01);
    push_exp("rw_doa_rf", RF_DOA,  2'b00);
    push_exp("rw_doa_wf", WF_DOA,  2'b01);
    tick();
    check_sb();
    idle(); enb = 1'b1; addrb = 11'd5;
    push_exp("rw_new_wf", WF_DOB,  2'b10);
    push_exp("rw_new_rf", RF_DOB,  2'b10);
    push_exp("rw_nocoll", RF_COLL, 2'b00);
    tick();
    check_sb();

    // Output reset without enable: only the registered output obeys it.
    idle(); rstb = 1'b1;
    push_exp("rstb_doreg_noen", RG_DOB, 2'b11);
    push_exp("rstb_noen_hold",  WF_DOB, 2'b10);
    tick();
    check_sb();
    rstb = 1'b0;
    push_exp("doreg_reload", RG_DOB, 2'b10);
    tick();
    check_sb();

    // Output reset with enable during a write; the array still updates.
    enb = 1'b1; web = 1'b1; rstb = 1'b1; addrb = 11'd2; dib = 2'b10;
    push_exp("rstb_en_wf", WF_DOB, 2'b00);
    push_exp("rstb_en_nc", NC_DOB, 2'b00);
    tick();
    check_sb();
    web = 1'b0; rstb = 1'b0;
    push_exp("rstb_write_kept", WF_DOB, 2'b10);
    tick();
    check_sb();

    // RST_N pulse: outputs go to SRVAL at once, array and blocked writes.
    idle();
    #3 rst_n = 1'b0;
    push_exp("rst2_srval_b", RG_DOB,  2'b11);
    push_exp("rst2_dob",     WF_DOB,  2'b00);
    push_exp("rst2_doa",     WF_DOA,  2'b00);
    push_exp("rst2_coll",    WF_COLL, 2'b00);
    #1 check_sb();
    enb = 1'b1; web = 1'b1; addrb = 11'd3; dib = 2'b00;
    tick();
    idle();
    rst_n = 1'b1;
    ena = 1'b1; addra = 12'd11; enb = 1'b1; addrb = 11'd3;
    push_exp("keep_dob",       WF_DOB, 2'b11);
    push_exp("keep_doa",       WF_DOA, 2'b01);
    push_exp("doreg_a_lat1",   RG_DOA, 2'b00);
    tick();
    check_sb();
    idle();
    push_exp("doreg_keep_dob", RG_DOB, 2'b11);
    push_exp("doreg_a_lat2",   RG_DOA, 2'b01);
    tick();
    check_sb();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
